// File: rtl/move_entry_ctrl_pkg.sv
// Shared types and constants for the drop-button move entry controller.
package move_entry_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_DEBOUNCE     = 2'd1,
    ST_ISSUE        = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } state_t;

  localparam int NUM_COLS_DEFAULT = 7;
  localparam int NUM_ROWS         = 6;
  localparam int COUNT_W          = 6;

  localparam logic PLAYER_1 = 1'b0;
  localparam logic PLAYER_2 = 1'b1;

endpackage

// File: rtl/move_entry_ctrl_if.sv
// Move request handshake between the entry controller (master) and the board logic (slave).
interface move_entry_ctrl_if;

  logic       move_valid;
  logic       move_ready;
  logic [2:0] move_col;
  logic       move_player;
  logic       move_err;

  modport master (
    output move_valid,
    output move_col,
    output move_player,
    output move_err,
    input  move_ready
  );

  modport slave (
    input  move_valid,
    input  move_col,
    input  move_player,
    input  move_err,
    output move_ready
  );

endinterface

// File: rtl/move_entry_ctrl_btn_debounce.sv
// Two-flop synchronizer plus a run-length counter of identical samples for the drop button.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  input  logic clear,
  output logic level,
  output logic press,
  output logic stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] SAT  = CW'(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic          level_q;
  logic [CW-1:0] cnt;

  // The counter restarts on any level change and saturates one past LAST so press fires once.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep this flop chain shifting one stage per edge.
      sync1   <= btn_raw;
      sync2   <= sync1;
      level_q <= sync2;
      if (clear || (sync2 != level_q)) begin
        cnt <= '0;
      end else if (cnt != SAT) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign level  = sync2;
  assign press  = sync2 && !clear && (cnt == LAST);
  assign stable = (sync2 == level_q) && (cnt >= LAST);

endmodule

// File: rtl/move_entry_ctrl.sv
// Drop-button move entry controller; define MOVE_COUNT_EN to add move_count/board_full.
module move_entry_ctrl
  import move_entry_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_COLS        = NUM_COLS_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_raw,
  input  logic [3:0]          sw_col,
  input  logic [NUM_COLS-1:0] col_full,
  input  logic                game_active,
  move_entry_ctrl_if.master   mv
`ifdef MOVE_COUNT_EN
  ,
  output logic [COUNT_W-1:0]  move_count,
  output logic                board_full
`endif
);

  state_t     state;
  logic       valid_q;
  logic [2:0] col_q;
  logic       player_q;
  logic       err_q;
  logic       level;
  logic       press;
  logic       stable;
  logic       col_ok;
  logic       legal;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_raw),
    .clear  (state == ST_IDLE),
    .level  (level),
    .press  (press),
    .stable (stable)
  );

  // Compare against each legal column so out-of-range switch values never index col_full.
  always_comb begin
    // NOTE: default first so no path through the loop leaves col_ok unassigned (no latch).
    col_ok = 1'b0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (sw_col == 4'(i)) col_ok = !col_full[i];
    end
  end

`ifdef MOVE_COUNT_EN
  localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(NUM_COLS * NUM_ROWS);
  logic [COUNT_W-1:0] count_q;

  assign board_full = (count_q == FULL_COUNT);
  assign move_count = count_q;
  assign legal      = col_ok && game_active && !board_full;
`else
  assign legal      = col_ok && game_active;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      valid_q  <= 1'b0;
      col_q    <= '0;
      player_q <= PLAYER_1;
      err_q    <= 1'b0;
`ifdef MOVE_COUNT_EN
      count_q  <= '0;
`endif
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (level) state <= ST_DEBOUNCE;
        end
        ST_DEBOUNCE: begin
          if (!level) begin
            state <= ST_IDLE;
          end else if (press) begin
            if (legal) begin
              state   <= ST_ISSUE;
              valid_q <= 1'b1;
              col_q   <= sw_col[2:0];
            end else begin
              state <= ST_WAIT_RELEASE;
              err_q <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          // A handshake in the same cycle as game_active falling still completes.
          if (mv.move_ready) begin
            state    <= ST_WAIT_RELEASE;
            valid_q  <= 1'b0;
            player_q <= ~player_q;
`ifdef MOVE_COUNT_EN
            if (count_q != FULL_COUNT) count_q <= count_q + COUNT_W'(1);
`endif
          end else if (!game_active) begin
            state   <= ST_WAIT_RELEASE;
            valid_q <= 1'b0;
          end
        end
        ST_WAIT_RELEASE: begin
          if (!level && stable) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mv.move_valid  = valid_q;
  assign mv.move_col    = col_q;
  assign mv.move_player = player_q;
  assign mv.move_err    = err_q;

endmodule

// File: tb/tb_move_entry_ctrl.sv
// Directed bench for move_entry_ctrl with a move scoreboard; define MOVE_COUNT_EN to cover the counter.
module tb_move_entry_ctrl;
  import move_entry_ctrl_pkg::*;

  localparam int DEB = 4;
  localparam int NC  = 7;

  logic          clk         = 1'b0;
  logic          reset       = 1'b0;
  logic          btn_raw     = 1'b0;
  logic          game_active = 1'b1;
  logic [3:0]    sw_col      = 4'd0;
  logic [NC-1:0] col_full    = '0;

  move_entry_ctrl_if mv_if ();

`ifdef MOVE_COUNT_EN
  logic [5:0] move_count;
  logic       board_full;
`endif

  move_entry_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .NUM_COLS       (NC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .sw_col     (sw_col),
    .col_full   (col_full),
    .game_active(game_active),
    .mv         (mv_if)
`ifdef MOVE_COUNT_EN
    ,
    .move_count (move_count),
    .board_full (board_full)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] col;
    logic       player;
  } move_t;

  move_t sb[$];
  int    vectors      = 0;
  int    miscompares  = 0;
  int    hs_cnt       = 0;
  int    err_cycles   = 0;
  int    valid_cycles = 0;
  logic  exp_player   = PLAYER_1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input int limit, output int cyc);
    cyc = 0;
    while (mv_if.move_valid !== 1'b1 && cyc < limit) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("wait_valid_seen", mv_if.move_valid, 1);
  endtask

  // Every valid cycle is matched against the oldest expected move; a handshake retires it.
  always @(negedge clk) begin
    if (reset) begin
      if (mv_if.move_valid === 1'b1) begin
        valid_cycles++;
        check("sb_nonempty", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          check("move_col", mv_if.move_col, sb[0].col);
          check("move_player", mv_if.move_player, sb[0].player);
          if (mv_if.move_ready === 1'b1) begin
            void'(sb.pop_front());
            hs_cnt++;
          end
        end
      end
      if (mv_if.move_err === 1'b1) err_cycles++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cyc;
    int h0;
    int e0;
    int v0;

    mv_if.move_ready = 1'b0;
    reset = 1'b0;
    tick(3);
    check("rst_valid", mv_if.move_valid, 0);
    check("rst_col", mv_if.move_col, 0);
    check("rst_player", mv_if.move_player, 0);
    check("rst_err", mv_if.move_err, 0);
    check("rst_state", dut.state, ST_IDLE);
    reset = 1'b1;
    tick(2);

    // Held press, ready already high: one move to column 3 by player 1.
    sw_col = 4'd3;
    mv_if.move_ready = 1'b1;
    h0 = hs_cnt; e0 = err_cycles; v0 = valid_cycles;
    sb.push_back(move_t'{3'd3, exp_player});
    btn_raw = 1'b1;
    wait_valid(20, cyc);
    // Two synchronizer stages ahead of the DEB+1 cycle debounce-to-valid latency.
    check("latency", cyc, DEB + 3);
    tick(3);
    btn_raw = 1'b0;
    exp_player = ~exp_player;
    tick(15);
    check("held_one_transfer", hs_cnt - h0, 1);
    check("held_valid_cycles", valid_cycles - v0, 1);
    check("held_no_err", err_cycles - e0, 0);
    check("held_player_after", mv_if.move_player, exp_player);

    // Two-cycle glitch is shorter than the debounce window.
    h0 = hs_cnt; e0 = err_cycles; v0 = valid_cycles;
    btn_raw = 1'b1;
    tick(2);
    btn_raw = 1'b0;
    tick(15);
    check("glitch_no_valid", valid_cycles - v0, 0);
    check("glitch_no_err", err_cycles - e0, 0);
    check("glitch_state", dut.state, ST_IDLE);

    // Out-of-range column.
    h0 = hs_cnt; e0 = err_cycles; v0 = valid_cycles;
    sw_col = 4'd9;
    btn_raw = 1'b1;
    tick(10);
    btn_raw = 1'b0;
    tick(15);
    check("col9_err_pulse", err_cycles - e0, 1);
    check("col9_no_valid", valid_cycles - v0, 0);

    // Full column.
    e0 = err_cycles; v0 = valid_cycles;
    sw_col = 4'd2;
    col_full = 7'b0000100;
    btn_raw = 1'b1;
    tick(10);
    btn_raw = 1'b0;
    tick(15);
    check("full_err_pulse", err_cycles - e0, 1);
    check("full_no_valid", valid_cycles - v0, 0);

    // Game not active.
    e0 = err_cycles; v0 = valid_cycles;
    col_full = '0;
    sw_col = 4'd1;
    game_active = 1'b0;
    btn_raw = 1'b1;
    tick(10);
    btn_raw = 1'b0;
    tick(15);
    game_active = 1'b1;
    check("inactive_err_pulse", err_cycles - e0, 1);
    check("inactive_no_valid", valid_cycles - v0, 0);
    check("player_unchanged", mv_if.move_player, exp_player);

    // Backpressure: column stays latched at 3 while switches move to 5.
    h0 = hs_cnt; v0 = valid_cycles;
    sw_col = 4'd3;
    mv_if.move_ready = 1'b0;
    sb.push_back(move_t'{3'd3, exp_player});
    btn_raw = 1'b1;
    wait_valid(20, cyc);
    sw_col = 4'd5;
    tick(5);
    mv_if.move_ready = 1'b1;
    tick(1);
    check("bp_valid_dropped", mv_if.move_valid, 0);
    btn_raw = 1'b0;
    exp_player = ~exp_player;
    tick(15);
    check("bp_valid_cycles", valid_cycles - v0, 6);
    check("bp_one_transfer", hs_cnt - h0, 1);
    check("bp_player_after", mv_if.move_player, exp_player);

    // Withdraw when game_active falls mid-request.
    h0 = hs_cnt;
    sw_col = 4'd4;
    mv_if.move_ready = 1'b0;
    sb.push_back(move_t'{3'd4, exp_player});
    btn_raw = 1'b1;
    wait_valid(20, cyc);
    game_active = 1'b0;
    tick(1);
    check("withdraw_valid", mv_if.move_valid, 0);
    check("withdraw_player", mv_if.move_player, exp_player);
    sb.delete();
    game_active = 1'b1;
    btn_raw = 1'b0;
    tick(15);
    check("withdraw_no_transfer", hs_cnt - h0, 0);
    check("withdraw_state", dut.state, ST_IDLE);

    // One more move so player 2 is current before the reset test.
    mv_if.move_ready = 1'b1;
    sw_col = 4'd6;
    sb.push_back(move_t'{3'd6, exp_player});
    btn_raw = 1'b1;
    wait_valid(20, cyc);
    tick(1);
    btn_raw = 1'b0;
    exp_player = ~exp_player;
    tick(15);
    check("pre_reset_player", mv_if.move_player, PLAYER_2);

    // Reset during ISSUE drops the request without a handshake.
    mv_if.move_ready = 1'b0;
    sw_col = 4'd1;
    sb.push_back(move_t'{3'd1, exp_player});
    btn_raw = 1'b1;
    wait_valid(20, cyc);
    reset = 1'b0;
    tick(1);
    check("midrst_valid", mv_if.move_valid, 0);
    check("midrst_player", mv_if.move_player, PLAYER_1);
    check("midrst_col", mv_if.move_col, 0);
    check("midrst_state", dut.state, ST_IDLE);
    sb.delete();
    exp_player = PLAYER_1;
    btn_raw = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(5);

`ifdef MOVE_COUNT_EN
    check("cnt_reset", move_count, 0);
    check("cnt_not_full", board_full, 0);
    mv_if.move_ready = 1'b1;
    for (int i = 0; i < NC * NUM_ROWS; i++) begin
      sw_col = 4'(i % NC);
      sb.push_back(move_t'{3'(i % NC), exp_player});
      btn_raw = 1'b1;
      wait_valid(20, cyc);
      tick(1);
      btn_raw = 1'b0;
      exp_player = ~exp_player;
      tick(12);
    end
    check("cnt_42", move_count, 42);
    check("cnt_board_full", board_full, 1);
    e0 = err_cycles; v0 = valid_cycles;
    sw_col = 4'd0;
    btn_raw = 1'b1;
    tick(10);
    btn_raw = 1'b0;
    tick(15);
    check("cnt_43rd_err", err_cycles - e0, 1);
    check("cnt_43rd_no_valid", valid_cycles - v0, 0);
    check("cnt_saturated", move_count, 42);
`endif

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
